// File: rtl/mult_acc.sv
// Sums LEN consecutive valid products into a frame total with a one-cycle acc_vld strobe; total registered the cycle after the last product, never back-pressures.
// Optional MULT_ACC_SAT_EN: clamp the running sum to all-ones on carry-out instead of wrapping.
module mult_acc #(
  parameter int W     = 12,
  parameter int LEN   = 8,
  parameter int ACC_W = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     res_rdy,
  input  logic [W-1:0]             res,
  input  logic                     clr,
  output logic                     acc_vld,
  output logic [ACC_W-1:0]         acc_out,
  output logic                     ovf,
  output logic [$clog2(LEN)-1:0]   fill,
  output logic                     busy
);

  localparam int FILL_W = $clog2(LEN);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LEN - 1);

  logic [FILL_W-1:0] fill_q, fill_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic              ovf_r_q, ovf_r_d;
  logic [ACC_W-1:0]  acc_out_q, acc_out_d;
  logic              ovf_q, ovf_d;
  logic              acc_vld_q, acc_vld_d;
  logic              busy_q, busy_d;

  logic [ACC_W:0]    res_ext;
  logic [ACC_W:0]    sum_ext;
  logic              carry;
  logic [ACC_W-1:0]  sum_nxt;

  always_comb begin
    res_ext          = '0;
    res_ext[W-1:0]   = res;
    sum_ext          = {1'b0, sum_q} + res_ext;
    carry            = sum_ext[ACC_W];
`ifdef MULT_ACC_SAT_EN
    // Once clamped, every further non-zero product carries again, so the sum stays pinned.
    sum_nxt          = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    sum_nxt          = sum_ext[ACC_W-1:0];
`endif

    fill_d    = fill_q;
    sum_d     = sum_q;
    ovf_r_d   = ovf_r_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;
    acc_vld_d = 1'b0;

    if (clr) begin
      fill_d  = '0;
      sum_d   = '0;
      ovf_r_d = 1'b0;
    end else if (res_rdy) begin
      if (fill_q == '0) begin
        sum_d   = res_ext[ACC_W-1:0];
        ovf_r_d = 1'b0;
        fill_d  = FILL_ONE;
      end else if (fill_q == FILL_LAST) begin
        acc_out_d = sum_nxt;
        ovf_d     = ovf_r_q | carry;
        acc_vld_d = 1'b1;
        fill_d    = '0;
        sum_d     = '0;
        ovf_r_d   = 1'b0;
      end else begin
        sum_d   = sum_nxt;
        fill_d  = fill_q + FILL_ONE;
        ovf_r_d = ovf_r_q | carry;
      end
    end

    busy_d = (fill_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q    <= '0;
      sum_q     <= '0;
      ovf_r_q   <= 1'b0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
      acc_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      fill_q    <= fill_d;
      sum_q     <= sum_d;
      ovf_r_q   <= ovf_r_d;
      acc_out_q <= acc_out_d;
      ovf_q     <= ovf_d;
      acc_vld_q <= acc_vld_d;
      busy_q    <= busy_d;
    end
  end

  assign acc_vld = acc_vld_q;
  assign acc_out = acc_out_q;
  assign ovf     = ovf_q;
  assign fill    = fill_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mult_acc.sv
// Directed, table-driven bench for mult_acc: default-size instance plus a W=12/LEN=4/ACC_W=12 instance for overflow.
module tb_mult_acc;

  logic        clk = 1'b0;
  logic        rst;

  logic        res_rdy, clr;
  logic [11:0] res;
  logic        acc_vld;
  logic [14:0] acc_out;
  logic        ovf;
  logic [2:0]  fill;
  logic        busy;

  logic        res_rdy2, clr2;
  logic [11:0] res2;
  logic        acc_vld2;
  logic [11:0] acc_out2;
  logic        ovf2;
  logic [1:0]  fill2;
  logic        busy2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mult_acc u_dut (
    .clk(clk), .rst(rst), .res_rdy(res_rdy), .res(res), .clr(clr),
    .acc_vld(acc_vld), .acc_out(acc_out), .ovf(ovf), .fill(fill), .busy(busy)
  );

  mult_acc #(.W(12), .LEN(4), .ACC_W(12)) u_ovf (
    .clk(clk), .rst(rst), .res_rdy(res_rdy2), .res(res2), .clr(clr2),
    .acc_vld(acc_vld2), .acc_out(acc_out2), .ovf(ovf2), .fill(fill2), .busy(busy2)
  );

  typedef struct {
    logic        rdy;
    logic [11:0] res;
    logic        clr;
    logic        vld;
    logic [14:0] out;
    logic        ovf;
    logic [2:0]  fill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input int r, input logic c,
                     input logic v, input int o, input logic f, input int fl);
    vec_t t;
    t.rdy  = rdy;
    t.res  = 12'(r);
    t.clr  = c;
    t.vld  = v;
    t.out  = 15'(o);
    t.ovf  = f;
    t.fill = 3'(fl);
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic rdy, input int r, input logic c);
    @(negedge clk);
    res_rdy = rdy;
    res     = 12'(r);
    clr     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic rdy, input int r);
    @(negedge clk);
    res_rdy2 = rdy;
    res2     = 12'(r);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic v, input int o, input logic f, input int fl);
    chk({tag, ".acc_vld"}, 32'(acc_vld), 32'(v));
    chk({tag, ".acc_out"}, 32'(acc_out), 32'(o));
    chk({tag, ".ovf"},     32'(ovf),     32'(f));
    chk({tag, ".fill"},    32'(fill),    32'(fl));
    chk({tag, ".busy"},    32'(busy),    32'(fl != 0));
  endtask

  int exp_sat;

  initial begin
    rst = 1'b1; res_rdy = 1'b0; res = '0; clr = 1'b0;
    res_rdy2 = 1'b0; res2 = '0; clr2 = 1'b0;

    // Back-to-back frame 1..8 -> 36
    for (int i = 1; i <= 7; i++) add(1, i, 0, 0, 0, 0, i);
    add(1, 8, 0, 1, 36, 0, 0);
    add(0, 0, 0, 0, 36, 0, 0);
    // Gapped frame 1..8 with idle cycles between products
    for (int i = 1; i <= 7; i++) begin
      add(1, i, 0, 0, 36, 0, i);
      add(0, 99, 0, 0, 36, 0, i);
    end
    add(1, 8, 0, 1, 36, 0, 0);
    add(0, 0, 0, 0, 36, 0, 0);
    // Abort after 5 products, clr with a coincident product, then 8 x 100 -> 800
    for (int i = 1; i <= 5; i++) add(1, 7, 0, 0, 36, 0, i);
    add(1, 50, 1, 0, 36, 0, 0);
    for (int i = 1; i <= 7; i++) add(1, 100, 0, 0, 36, 0, i);
    add(1, 100, 0, 1, 800, 0, 0);
    // clr coincident with the 8th product: frame discarded, no strobe
    for (int i = 1; i <= 7; i++) add(1, 3, 0, 0, 800, 0, i);
    add(1, 3, 1, 0, 800, 0, 0);
    add(0, 0, 0, 0, 800, 0, 0);
    // Products of mult_man (N=8,M=4) pairs (25,5)...(4,4) -> 460
    add(1, 125, 0, 0, 800, 0, 1);
    add(1, 160, 0, 0, 800, 0, 2);
    add(1, 40,  0, 0, 800, 0, 3);
    add(1, 105, 0, 0, 800, 0, 4);
    add(1, 1,   0, 0, 800, 0, 5);
    add(1, 4,   0, 0, 800, 0, 6);
    add(1, 9,   0, 0, 800, 0, 7);
    add(1, 16,  0, 1, 460, 0, 0);
    // Max-value frame 8 x 4095 = 32760 fits in 15 bits
    for (int i = 1; i <= 7; i++) add(1, 4095, 0, 0, 460, 0, i);
    add(1, 4095, 0, 1, 32760, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk_main("reset", 0, 0, 0, 0);
    chk("reset.acc_out2", 32'(acc_out2), 32'd0);
    chk("reset.fill2",    32'(fill2),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      step(vecs[k].rdy, int'(vecs[k].res), vecs[k].clr);
      chk_main($sformatf("vec%0d", k), vecs[k].vld, int'(vecs[k].out), vecs[k].ovf, int'(vecs[k].fill));
    end

    // Reset mid-frame: partial frame lost, held total cleared, no strobe
    step(0, 0, 0);
    for (int i = 1; i <= 3; i++) step(1, 2, 0);
    chk_main("pre_rst", 0, 32760, 0, 3);
    @(negedge clk);
    rst = 1'b1; res_rdy = 1'b1; res = 12'd2;
    @(posedge clk);
    #1;
    chk_main("mid_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; res_rdy = 1'b0;
    for (int i = 1; i <= 7; i++) step(1, 2, 0);
    chk_main("rst_f7", 0, 0, 0, 7);
    step(1, 2, 0);
    chk_main("rst_frame", 1, 16, 0, 0);
    step(0, 0, 0);
    chk_main("rst_hold", 0, 16, 0, 0);

    // Overflow on the narrow instance: 4 x 4095
`ifdef MULT_ACC_SAT_EN
    exp_sat = 4095;
`else
    exp_sat = 4092;
`endif
    for (int i = 1; i <= 3; i++) step2(1, 4095);
    chk("ovf.fill3", 32'(fill2), 32'd3);
    chk("ovf.vld_early", 32'(acc_vld2), 32'd0);
    step2(1, 4095);
    chk("ovf.acc_vld", 32'(acc_vld2), 32'd1);
    chk("ovf.acc_out", 32'(acc_out2), 32'(exp_sat));
    chk("ovf.ovf",     32'(ovf2),     32'd1);
    chk("ovf.fill",    32'(fill2),    32'd0);
    step2(0, 0);
    chk("ovf.hold_out", 32'(acc_out2), 32'(exp_sat));
    chk("ovf.hold_ovf", 32'(ovf2),     32'd1);
    chk("ovf.vld_drop", 32'(acc_vld2), 32'd0);
    for (int i = 1; i <= 4; i++) step2(1, 1);
    chk("clean.acc_vld", 32'(acc_vld2), 32'd1);
    chk("clean.acc_out", 32'(acc_out2), 32'd4);
    chk("clean.ovf",     32'(ovf2),     32'd0);
    chk("clean.busy",    32'(busy2),    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
